// File: rtl/gb_dma_pkg.sv
// rtl/gb_dma_pkg.sv - shared types and constants for the OAM DMA controller
package gb_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    localparam int         OAM_LEN   = 160;
    localparam logic [7:0] ECHO_MASK = 8'hDF;
    localparam logic [7:0] ECHO_BASE = 8'hE0;

    // Echo RAM (E0-FF) mirrors WRAM, so those source pages are folded onto C0-DF.
    function automatic logic [7:0] fold_src(input logic [7:0] src);
        return (src >= ECHO_BASE) ? (src & ECHO_MASK) : src;
    endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - OAM DMA sequencer triggered by FF46 writes
//
// Ports:
//   clock, reset         core clock, asynchronous active-high reset
//   cfg_we/cfg_wdata     FF46 write strobe and source high byte
//   cfg_rdata            last value written to FF46 (unfolded)
//   dma_active           bus owned by DMA (START or XFER)
//   dma_A/dma_rd_n/dma_Di shared bus address, read strobe, read data
//   oam_addr/oam_wdata/oam_we  dedicated OAM write port
module oam_dma_controller
    import gb_dma_pkg::*;
#(
    parameter int CPB = 4,
    parameter int LEN = OAM_LEN
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_wdata,
    output logic [7:0]  cfg_rdata,
    output logic        dma_active,
    output logic [15:0] dma_A,
    output logic        dma_rd_n,
    input  logic [7:0]  dma_Di,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we
);

    localparam int             PW         = $clog2(CPB);
    localparam logic [PW-1:0]  PHASE_LAST = PW'(CPB - 1);
    localparam logic [7:0]     IDX_LAST   = 8'(LEN - 1);

    dma_state_t    state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic [7:0]    idx, idx_n;
    logic [7:0]    src_raw;
    logic [7:0]    src_eff;
    logic          phase_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= '0;
            idx     <= 8'h00;
            src_raw <= 8'h00;
            src_eff <= 8'h00;
        end else begin
            state <= state_n;
            phase <= phase_n;
            idx   <= idx_n;
            if (cfg_we) begin
                src_raw <= cfg_wdata;
                src_eff <= fold_src(cfg_wdata);
            end
        end
    end

    assign phase_done = (phase == PHASE_LAST);

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        idx_n      = idx;
        dma_active = 1'b0;
        dma_rd_n   = 1'b1;
        oam_we     = 1'b0;

        case (state)
            IDLE: begin
            end
            START: begin
                dma_active = 1'b1;
                if (phase_done) begin
                    state_n = XFER;
                    phase_n = '0;
                    idx_n   = 8'h00;
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            XFER: begin
                dma_active = 1'b1;
                dma_rd_n   = 1'b0;
                if (phase_done) begin
                    oam_we  = 1'b1;
                    phase_n = '0;
                    if (idx == IDX_LAST) begin
                        state_n = IDLE;
                    end else begin
                        idx_n = idx + 8'd1;
                    end
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
            end
        endcase

        // A new FF46 write wins over everything, including the final byte:
        // the in-flight byte is dropped and the copy restarts from scratch.
        if (cfg_we) begin
            state_n = START;
            phase_n = '0;
            idx_n   = 8'h00;
            oam_we  = 1'b0;
        end
    end

    assign cfg_rdata = src_raw;
    assign dma_A     = {src_eff, idx};
    assign oam_addr  = idx;
    // Gate the pass-through so the write port reads zero whenever no write is issued.
    assign oam_wdata = oam_we ? dma_Di : 8'h00;

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - directed self-checking bench for oam_dma_controller
module tb_oam_dma_controller;
    import gb_dma_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_we, cfg_we2;
    logic [7:0]  cfg_wdata, cfg_wdata2;
    logic [7:0]  cfg_rdata, cfg_rdata2;
    logic        dma_active, dma_active2;
    logic [15:0] dma_A, dma_A2;
    logic        dma_rd_n, dma_rd_n2;
    logic [7:0]  dma_Di, dma_Di2;
    logic [7:0]  oam_addr, oam_addr2;
    logic [7:0]  oam_wdata, oam_wdata2;
    logic        oam_we, oam_we2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    // Source memory: byte at C0xx is xx^5A, other pages add a page-dependent offset.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ {a[11:8], 4'h0};
    endfunction

    assign dma_Di  = pat(dma_A);
    assign dma_Di2 = pat(dma_A2);

    oam_dma_controller #(.CPB(4)) dut (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .dma_active(dma_active), .dma_A(dma_A), .dma_rd_n(dma_rd_n), .dma_Di(dma_Di),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we)
    );

    oam_dma_controller #(.CPB(2)) dut2 (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we2), .cfg_wdata(cfg_wdata2), .cfg_rdata(cfg_rdata2),
        .dma_active(dma_active2), .dma_A(dma_A2), .dma_rd_n(dma_rd_n2), .dma_Di(dma_Di2),
        .oam_addr(oam_addr2), .oam_wdata(oam_wdata2), .oam_we(oam_we2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drives cfg_we for one clock starting at this negedge; the caller may
    // sample the write cycle before the next negedge clears the strobe.
    task automatic write_cfg(input bit d2, input logic [7:0] v);
        @(negedge clock);
        if (d2) begin
            cfg_we2 = 1'b1; cfg_wdata2 = v;
        end else begin
            cfg_we = 1'b1; cfg_wdata = v;
        end
        #1;
    endtask

    // Walks cycles 1..ncyc after a write and compares every cycle against the
    // expected schedule: START in 1..cpb, byte i written at cycle cpb*(i+2).
    task automatic watch(input bit d2, input int cpb, input logic [7:0] se, input int ncyc,
                         output int pulses, output int errs, output int first,
                         output int last, output int act_lows, output logic act_end);
        int          fin;
        int          i;
        logic [7:0]  ia;
        logic        we, rd, ac, exp_we, exp_rd;
        logic [7:0]  ad, wd;
        logic [15:0] a;
        fin = cpb + OAM_LEN * cpb;
        pulses = 0; errs = 0; first = -1; last = -1; act_lows = 0; act_end = 1'b0;
        for (int rel = 1; rel <= ncyc; rel++) begin
            @(negedge clock);
            cfg_we = 1'b0; cfg_we2 = 1'b0;
            #1;
            if (d2) begin
                we = oam_we2; rd = dma_rd_n2; ac = dma_active2; ad = oam_addr2; wd = oam_wdata2; a = dma_A2;
            end else begin
                we = oam_we; rd = dma_rd_n; ac = dma_active; ad = oam_addr; wd = oam_wdata; a = dma_A;
            end
            exp_we = (rel >= 2 * cpb) && (rel % cpb == 0) && (rel <= fin);
            exp_rd = !((rel > cpb) && (rel <= fin));
            if (we !== exp_we || rd !== exp_rd) errs++;
            if (we === 1'b1) begin
                pulses++;
                if (first < 0) first = rel;
                last = rel;
                i  = rel / cpb - 2;
                ia = i[7:0];
                if (ad !== ia || wd !== pat({se, ia}) || a !== {se, ia}) errs++;
            end
            if (rel <= fin && ac !== 1'b1) act_lows++;
            act_end = ac;
        end
    endtask

    int   pulses, errs, first, last, act_lows;
    logic act_end;

    initial begin
        reset = 1'b1;
        cfg_we = 1'b0; cfg_wdata = 8'h00;
        cfg_we2 = 1'b0; cfg_wdata2 = 8'h00;
        #1;
        check_eq("rst_active", dma_active, 0);
        check_eq("rst_rd_n", dma_rd_n, 1);
        check_eq("rst_A", dma_A, 16'h0000);
        check_eq("rst_oam_we", oam_we, 0);
        check_eq("rst_oam_addr", oam_addr, 0);
        check_eq("rst_oam_wdata", oam_wdata, 0);
        check_eq("rst_rdata", cfg_rdata, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Basic copy from C000
        write_cfg(0, 8'hC0);
        watch(0, 4, 8'hC0, 645, pulses, errs, first, last, act_lows, act_end);
        check_eq("copy_pulses", pulses, 160);
        check_eq("copy_errs", errs, 0);
        check_eq("copy_first", first, 8);
        check_eq("copy_last", last, 644);
        check_eq("copy_act_lows", act_lows, 0);
        check_eq("copy_act_end", act_end, 0);
        check_eq("copy_rdata", cfg_rdata, 8'hC0);

        // Echo fold: E1 reads from C1xx
        write_cfg(0, 8'hE1);
        watch(0, 4, 8'hC1, 645, pulses, errs, first, last, act_lows, act_end);
        check_eq("echo_pulses", pulses, 160);
        check_eq("echo_errs", errs, 0);
        check_eq("echo_rdata", cfg_rdata, 8'hE1);
        check_eq("echo_act_end", act_end, 0);

        // Restart while writing idx=50 (its phase 3)
        write_cfg(0, 8'hC0);
        watch(0, 4, 8'hC0, 207, pulses, errs, first, last, act_lows, act_end);
        check_eq("rs1_pulses", pulses, 50);
        check_eq("rs1_errs", errs, 0);
        check_eq("rs1_last", last, 204);
        write_cfg(0, 8'hC2);
        check_eq("rs_we_suppressed", oam_we, 0);
        check_eq("rs_active", dma_active, 1);
        watch(0, 4, 8'hC2, 645, pulses, errs, first, last, act_lows, act_end);
        check_eq("rs2_pulses", pulses, 160);
        check_eq("rs2_errs", errs, 0);
        check_eq("rs2_act_lows", act_lows, 0);
        check_eq("rs2_act_end", act_end, 0);

        // Collision with the final byte
        write_cfg(0, 8'hC0);
        watch(0, 4, 8'hC0, 643, pulses, errs, first, last, act_lows, act_end);
        check_eq("col1_pulses", pulses, 159);
        check_eq("col1_errs", errs, 0);
        write_cfg(0, 8'hC3);
        check_eq("col_we_suppressed", oam_we, 0);
        check_eq("col_active", dma_active, 1);
        watch(0, 4, 8'hC3, 645, pulses, errs, first, last, act_lows, act_end);
        check_eq("col2_pulses", pulses, 160);
        check_eq("col2_errs", errs, 0);
        check_eq("col2_act_end", act_end, 0);

        // CPB=2 sweep
        write_cfg(1, 8'hC0);
        watch(1, 2, 8'hC0, 323, pulses, errs, first, last, act_lows, act_end);
        check_eq("cpb2_pulses", pulses, 160);
        check_eq("cpb2_errs", errs, 0);
        check_eq("cpb2_first", first, 4);
        check_eq("cpb2_last", last, 322);
        check_eq("cpb2_act_end", act_end, 0);

        // Reset mid-stream at idx=37
        write_cfg(0, 8'hC1);
        watch(0, 4, 8'hC1, 154, pulses, errs, first, last, act_lows, act_end);
        check_eq("mid_pulses", pulses, 37);
        check_eq("mid_errs", errs, 0);
        check_eq("mid_addr", oam_addr, 37);
        reset = 1'b1;
        #1;
        check_eq("mrst_active", dma_active, 0);
        check_eq("mrst_rd_n", dma_rd_n, 1);
        check_eq("mrst_A", dma_A, 16'h0000);
        check_eq("mrst_oam_we", oam_we, 0);
        check_eq("mrst_oam_addr", oam_addr, 0);
        check_eq("mrst_oam_wdata", oam_wdata, 0);
        check_eq("mrst_rdata", cfg_rdata, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        check_eq("post_rst_idle", dma_active, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
